// File: rtl/ps2_pkg.sv
// PS/2 receive path shared definitions: FSM encoding, frame size
// and scan-code prefixes also used by the capture stage.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DPS  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] BRK = 8'hF0;
  localparam logic [7:0] EXT = 8'hE0;

endpackage

// File: rtl/filtro_ps2.sv
// PS/2 line conditioning: 2-FF synchronisers, keyboard clock
// de-glitch filter and filtered-clock falling edge detector.
module filtro_ps2 #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic dato_raw,
  input  logic clock_raw,
  output logic dato_s,
  output logic clock_f,
  output logic fall_edge
);

  logic [1:0]            d_sync;
  logic [1:0]            c_sync;
  logic [FILTER_LEN-1:0] muestras;
  logic                  clock_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_sync   <= 2'b11;
      c_sync   <= 2'b11;
      muestras <= '1;
      clock_f  <= 1'b1;
    end else begin
      d_sync   <= {d_sync[0], dato_raw};
      c_sync   <= {c_sync[0], clock_raw};
      muestras <= {c_sync[1], muestras[FILTER_LEN-1:1]};
      clock_f  <= clock_next;
    end
  end

  // level only moves once the whole window agrees
  always_comb begin
    clock_next = clock_f;
    unique case (1'b1)
      (&muestras):  clock_next = 1'b1;
      (~|muestras): clock_next = 1'b0;
      default:      clock_next = clock_f;
    endcase
  end

  assign fall_edge = clock_f & ~clock_next;
  assign dato_s    = d_sync[1];

endmodule

// File: rtl/receptor_ps2.sv
// PS/2 frame receiver: start, 8 data LSB-first, odd parity, stop.
// Define RX_PARITY_CHECK_EN to reject frames on parity/stop errors.
module receptor_ps2
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       datoTeclado,
  input  logic       clockTeclado,
  output logic       rx_done_tick,
  output logic       rx_err_tick,
  output logic [7:0] dout,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic                      dato_s;
  logic                      clock_f;
  logic                      fall_edge;
  state_t                    state;
  logic [PS2_FRAME_BITS-1:0] frame;
  logic [3:0]                n;
  logic [TW-1:0]             to_cnt;
  logic                      frame_ok;

  filtro_ps2 #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filtro (
    .clk      (clk),
    .rst      (rst),
    .dato_raw (datoTeclado),
    .clock_raw(clockTeclado),
    .dato_s   (dato_s),
    .clock_f  (clock_f),
    .fall_edge(fall_edge)
  );

`ifdef RX_PARITY_CHECK_EN
  logic unused_bits;
  assign unused_bits = ^{frame[0], clock_f};
  assign frame_ok = (^frame[9:1]) & frame[10];
`else
  logic unused_bits;
  assign unused_bits = ^{frame[10:9], frame[0], clock_f};
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      frame        <= '0;
      n            <= '0;
      to_cnt       <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      rx_err_tick  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      rx_err_tick  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          if (fall_edge && rx_en && !dato_s) begin
            frame <= {dato_s, frame[PS2_FRAME_BITS-1:1]};
            n     <= 4'd9;
            state <= ST_DPS;
            busy  <= 1'b1;
          end
        end
        ST_DPS: begin
          // an edge on the terminal count beats the timeout
          if (fall_edge) begin
            to_cnt <= '0;
            frame  <= {dato_s, frame[PS2_FRAME_BITS-1:1]};
            if (n == 4'd0) state <= ST_LOAD;
            else           n     <= n - 4'd1;
          end else if (to_cnt == TO_LAST) begin
            to_cnt      <= '0;
            rx_err_tick <= 1'b1;
            state       <= ST_IDLE;
            busy        <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (frame_ok) begin
            rx_done_tick <= 1'b1;
            dout         <= frame[8:1];
          end else begin
            rx_err_tick <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
